// File: rtl/uart_rx_sampler_if.sv
// Serial receiver bundle: line-side inputs, configuration and the per-frame
// result seen by the RX FIFO write logic.
//
// Handshake: rxValid is a one-clock strobe with no ready/back-pressure. On the
// clock where rxValid is 1, rxByte, parityErr and frameErr describe one frame;
// they hold their values until the next strobe. The consumer must take the
// frame on that clock (or ignore it); the receiver never waits.
interface uart_rx_sampler_if #(
    parameter int DATA_BITS = 8
);
    logic                 rxTick;
    logic                 rxSerial;
    logic                 osmSel;
    logic                 rxPen;
    logic                 rxEps;
    logic [DATA_BITS-1:0] rxByte;
    logic                 rxValid;
    logic                 parityErr;
    logic                 frameErr;
    logic                 rxBusy;

    // Receiver side
    modport slave (
        input  rxTick, rxSerial, osmSel, rxPen, rxEps,
        output rxByte, rxValid, parityErr, frameErr, rxBusy
    );

    // Line driver / consumer side
    modport master (
        output rxTick, rxSerial, osmSel, rxPen, rxEps,
        input  rxByte, rxValid, parityErr, frameErr, rxBusy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: synchronises the line, finds the start bit,
// majority-votes three mid-bit samples per bit, checks optional parity and the
// stop bit, and strobes one byte plus error flags per frame.
module uart_rx_sampler #(
    parameter int DATA_BITS = 8,
    parameter int OSR_HI    = 16,
    parameter int OSR_LO    = 13
) (
    input  logic                    clk,
    input  logic                    rstN,
    uart_rx_sampler_if.slave        rx_if,
    output logic [2:0]              dbg_state_o
);

    localparam int SMP_W = $clog2((OSR_HI > OSR_LO) ? OSR_HI : OSR_LO);
    localparam int BC_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SMP_W-1:0] LAST_HI = SMP_W'(OSR_HI - 1);
    localparam logic [SMP_W-1:0] LAST_LO = SMP_W'(OSR_LO - 1);
    localparam logic [SMP_W-1:0] MID_HI  = SMP_W'(OSR_HI / 2);
    localparam logic [SMP_W-1:0] MID_LO  = SMP_W'(OSR_LO / 2);
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Line path
    logic sync1_q;
    logic rx_s_q;
    logic prev_q;

    // Frame state
    logic [2:0]           state_q, state_d;
    logic [SMP_W-1:0]     smp_q, smp_d;
    logic [BC_W-1:0]      bc_q, bc_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 osm_q, osm_d;
    logic                 pen_q, pen_d;
    logic                 eps_q, eps_d;
    logic                 s0_q, s0_d;
    logic                 s1_q, s1_d;
    logic                 perr_q, perr_d;

    // Result registers
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_q, ferr_d;

    logic [SMP_W-1:0] smp_last;
    logic [SMP_W-1:0] smp_mid;
    logic             tick;
    logic             at_s0;
    logic             at_s1;
    logic             at_dec;
    logic             vote;

    // Bit-timing helpers derived from the OSR latched for this frame
    always_comb begin
        tick     = rx_if.rxTick;
        smp_last = osm_q ? LAST_LO : LAST_HI;
        smp_mid  = osm_q ? MID_LO : MID_HI;
        at_s0    = tick && (smp_q == smp_mid - SMP_W'(1));
        at_s1    = tick && (smp_q == smp_mid);
        at_dec   = tick && (smp_q == smp_mid + SMP_W'(1));
        // The third sample is the live synchronised line on the decision tick.
        vote     = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
    end

    // Two-flop synchroniser plus the last ticked sample for edge detection;
    // all reset to the idle-line level so release never looks like a start.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_if.rxSerial;
            rx_s_q  <= sync1_q;
            if (tick) begin
                prev_q <= rx_s_q;
            end
        end
    end

    // Frame FSM: sample counting, voting, shifting and end-of-frame reporting
    always_comb begin
        state_d    = state_q;
        smp_d      = smp_q;
        bc_d       = bc_q;
        shift_d    = shift_q;
        osm_d      = osm_q;
        pen_d      = pen_q;
        eps_d      = eps_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        perr_d     = perr_q;
        byte_d     = byte_q;
        valid_d    = 1'b0;
        perr_out_d = perr_out_q;
        ferr_d     = ferr_q;

        if (state_q != ST_IDLE && tick) begin
            smp_d = (smp_q == smp_last) ? '0 : smp_q + SMP_W'(1);
        end
        if (at_s0) begin
            s0_d = rx_s_q;
        end
        if (at_s1) begin
            s1_d = rx_s_q;
        end

        case (state_q)
            ST_IDLE: begin
                // prev_q stays 0 across a held-low break, so no re-trigger
                // until the line has been seen high on a tick.
                if (tick && !rx_s_q && prev_q) begin
                    smp_d   = '0;
                    osm_d   = rx_if.osmSel;
                    pen_d   = rx_if.rxPen;
                    eps_d   = rx_if.rxEps;
                    perr_d  = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (at_dec) begin
                    if (vote) begin
                        state_d = ST_IDLE;
                    end else begin
                        bc_d    = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (at_dec) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (bc_q == BC_LAST) begin
                        state_d = pen_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bc_d = bc_q + BC_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (at_dec) begin
                    perr_d  = ((^shift_q) ^ vote) != ~eps_q;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (at_dec) begin
                    byte_d     = shift_q;
                    perr_out_d = perr_q & pen_q;
                    ferr_d     = ~vote;
                    valid_d    = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame state and result registers; reset discards any partial frame
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= ST_IDLE;
            smp_q      <= '0;
            bc_q       <= '0;
            shift_q    <= '0;
            osm_q      <= 1'b0;
            pen_q      <= 1'b0;
            eps_q      <= 1'b0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            perr_q     <= 1'b0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            smp_q      <= smp_d;
            bc_q       <= bc_d;
            shift_q    <= shift_d;
            osm_q      <= osm_d;
            pen_q      <= pen_d;
            eps_q      <= eps_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            perr_q     <= perr_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rx_if.rxByte    = byte_q;
    assign rx_if.rxValid   = valid_q;
    assign rx_if.parityErr = perr_out_q;
    assign rx_if.frameErr  = ferr_q;
    assign rx_if.rxBusy    = (state_q != ST_IDLE);
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: directed frame table, hand-written corner
// sequences and random frames checked against a frame-level reference model.
module tb_uart_rx_sampler;

    localparam int EXP_W = 58;  // {start_tick[31:0], latency[15:0], ferr, perr, data[7:0]}

    logic       clk;
    logic       rstN;
    logic [2:0] dbg_state;

    uart_rx_sampler_if #(.DATA_BITS(8)) bus ();

    uart_rx_sampler #(.DATA_BITS(8), .OSR_HI(16), .OSR_LO(13)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .rx_if       (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared state ----------------
    int n_checks;
    int n_errors;
    int tick_div;
    int tick_seen;
    int got_cnt;
    logic prev_valid;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rule: parity error when enabled and the received parity bit
    // differs from the one that makes the ones-count even (or odd).
    function automatic bit model_perr(input logic [7:0] d, input bit pen, input bit eps, input bit par_bit);
        int ones;
        bit need;
        if (!pen) return 1'b0;
        ones = $countones(d);
        need = eps ? bit'(ones % 2) : bit'(1 - (ones % 2));
        return par_bit != need;
    endfunction

    // ---------------- tick counter ----------------
    always @(posedge clk) begin
        if (bus.rxTick === 1'b1) tick_seen++;
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (bus.rxValid === 1'b1) begin
            got_cnt++;
            check("valid_width", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid: got rxByte %0h with no frame expected at %0t", bus.rxByte, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("rx_byte", {24'd0, bus.rxByte}, {24'd0, mon_e[7:0]});
                check("parity_err", {31'd0, bus.parityErr}, {31'd0, mon_e[8]});
                check("frame_err", {31'd0, bus.frameErr}, {31'd0, mon_e[9]});
                check("latency", 32'(tick_seen - int'(mon_e[57:26]) - 1), {16'd0, mon_e[25:10]});
            end
        end
        prev_valid = bus.rxValid;
    end

    // ---------------- driver tasks ----------------
    task automatic tick1(input logic line);
        bus.rxSerial = line;
        for (int i = 0; i < tick_div - 1; i++) @(negedge clk);
        bus.rxTick = 1'b1;
        @(negedge clk);
        bus.rxTick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick1(1'b1);
    endtask

    task automatic pulse_reset();
        bus.rxSerial = 1'b1;
        bus.rxTick   = 1'b0;
        rstN         = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, bus.rxValid}, 32'd0);
        check("rst_busy", {31'd0, bus.rxBusy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pen, input bit eps, input bit osm,
                              input bit par_bit, input bit stop_bit, input bit exp_perr,
                              input int glitch_bit, input bit flip_cfg, input int abort_bit,
                              input bit expect_it);
        int n;
        int mid;
        int nb;
        int lag;
        bit seq[11];
        logic line;
        n   = osm ? 13 : 16;
        mid = n / 2;
        lag = (tick_div == 1) ? 2 : 0;
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[i+1] = d[i];
        nb = 9;
        if (pen) begin
            seq[9] = par_bit;
            nb = 10;
        end
        seq[nb] = stop_bit;
        nb = nb + 1;
        bus.osmSel = osm;
        bus.rxPen  = pen;
        bus.rxEps  = eps;
        if (expect_it)
            exp_q.push_back({32'(tick_seen), 16'(n * (9 + int'(pen)) + mid + 2 + lag), ~stop_bit, exp_perr, d});
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < n; k++) begin
                if (b == abort_bit && k == mid) begin
                    pulse_reset();
                    return;
                end
                if (flip_cfg && b == 4 && k == 0) begin
                    bus.osmSel = ~osm;
                    bus.rxPen  = ~pen;
                    bus.rxEps  = ~eps;
                end
                line = seq[b];
                if (glitch_bit >= 0 && b == glitch_bit + 1 && k == mid + 1) line = ~line;
                tick1(line);
            end
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0] data;
        bit         pen;
        bit         eps;
        bit         osm;
        bit         par_bit;
        int         glitch;
        bit         exp_perr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int base;
        logic [7:0] d;
        bit pen, eps, osm, par, stp, last_stop;
        int gl, gap;

        vecs[0] = '{data: 8'hA5, pen: 0, eps: 0, osm: 0, par_bit: 0, glitch: -1, exp_perr: 0};
        vecs[1] = '{data: 8'hD3, pen: 1, eps: 1, osm: 1, par_bit: 1, glitch: -1, exp_perr: 0};
        vecs[2] = '{data: 8'hD3, pen: 1, eps: 1, osm: 1, par_bit: 0, glitch: -1, exp_perr: 1};
        vecs[3] = '{data: 8'hFF, pen: 1, eps: 0, osm: 0, par_bit: 1, glitch: -1, exp_perr: 0};
        vecs[4] = '{data: 8'h5A, pen: 0, eps: 0, osm: 1, par_bit: 0, glitch: 3,  exp_perr: 0};

        n_checks   = 0;
        n_errors   = 0;
        tick_div   = 4;
        tick_seen  = 0;
        got_cnt    = 0;
        prev_valid = 1'b0;
        rstN         = 1'b0;
        bus.rxTick   = 1'b0;
        bus.rxSerial = 1'b1;
        bus.osmSel   = 1'b0;
        bus.rxPen    = 1'b0;
        bus.rxEps    = 1'b0;
        @(negedge clk);

        // Reset held with a toggling line
        for (int i = 0; i < 40; i++) tick1(1'($urandom_range(0, 1)));
        check("reset_rx_byte", {24'd0, bus.rxByte}, 32'd0);
        check("reset_valid", {31'd0, bus.rxValid}, 32'd0);
        check("reset_parity_err", {31'd0, bus.parityErr}, 32'd0);
        check("reset_frame_err", {31'd0, bus.frameErr}, 32'd0);
        check("reset_busy", {31'd0, bus.rxBusy}, 32'd0);
        bus.rxSerial = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        idle(50 * 16);
        check("idle_no_valid", 32'(got_cnt), 32'd0);
        check("idle_busy", {31'd0, bus.rxBusy}, 32'd0);

        // Directed frames
        for (int v = 0; v < 5; v++) begin
            base = got_cnt;
            send_frame(vecs[v].data, vecs[v].pen, vecs[v].eps, vecs[v].osm, vecs[v].par_bit,
                       1'b1, vecs[v].exp_perr, vecs[v].glitch, 1'b0, -1, 1'b1);
            idle(20);
            check("tbl_count", 32'(got_cnt - base), 32'd1);
            check("tbl_held_byte", {24'd0, bus.rxByte}, {24'd0, vecs[v].data});
            check("tbl_held_perr", {31'd0, bus.parityErr}, {31'd0, vecs[v].exp_perr});
            check("tbl_busy", {31'd0, bus.rxBusy}, 32'd0);
        end

        // Stop bit low, then line held low for three frames
        base = got_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, -1, 1'b1);
        for (int i = 0; i < 3 * 10 * 16; i++) tick1(1'b0);
        check("break_count", 32'(got_cnt - base), 32'd1);
        check("break_frame_err", {31'd0, bus.frameErr}, 32'd1);
        idle(20);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, -1, 1'b1);
        idle(20);
        check("break_recover", 32'(got_cnt - base), 32'd2);

        // Three-tick low glitch on an idle line
        base = got_cnt;
        tick1(1'b0);
        tick1(1'b0);
        tick1(1'b0);
        check("glitch_busy", {31'd0, bus.rxBusy}, 32'd1);
        idle(40);
        check("glitch_no_valid", 32'(got_cnt - base), 32'd0);
        check("glitch_idle", {31'd0, bus.rxBusy}, 32'd0);

        // Back-to-back, config flipped mid-frame, then reset mid third frame
        base = got_cnt;
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b1, -1, 1'b1);
        send_frame(8'h34, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b0, -1, 1'b1);
        send_frame(8'h56, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b0, 5, 1'b0);
        check("b2b_count", 32'(got_cnt - base), 32'd2);
        idle(30);
        check("after_reset_busy", {31'd0, bus.rxBusy}, 32'd0);
        check("after_reset_byte", {24'd0, bus.rxByte}, 32'd0);
        send_frame(8'h9A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, -1, 1'b1);
        idle(20);
        check("after_reset_frame", 32'(got_cnt - base), 32'd3);

        // Random frames, normal then continuous tick
        last_stop = 1'b1;
        for (int r = 0; r < 16; r++) begin
            if (r == 12) begin
                idle(20);
                tick_div = 1;
            end
            d   = 8'($urandom_range(0, 255));
            pen = 1'($urandom_range(0, 1));
            eps = 1'($urandom_range(0, 1));
            osm = 1'($urandom_range(0, 1));
            par = 1'($urandom_range(0, 1));
            stp = ($urandom_range(0, 7) != 0);
            gl  = $urandom_range(0, 15);
            if (gl > 7) gl = -1;
            gap = $urandom_range(0, 8);
            if (!last_stop && gap == 0) gap = 1;
            idle(gap);
            send_frame(d, pen, eps, osm, par, stp, model_perr(d, pen, eps, par), gl, 1'b0, -1, 1'b1);
            last_stop = stp;
        end
        idle(30);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
